// File: rtl/mod_mul_serial.sv
// mod_mul_serial: bit-serial, MSB-first interleaved modular multiplier.
// Computes o_R = (i_a * i_b) mod i_p, one multiplier bit per clock,
// using a single (Data_Width+1)-bit add/reduce datapath.
// A job started on edge k completes with o_done high in the cycle after
// edge k+Data_Width.
// Optional build macro MOD_MUL_RANGE_CHECK_EN: when defined, operands are
// range-checked at start. A bad job skips RUN and reports o_err one cycle later.
// When the macro is undefined, o_err is tied low and no range compare is built.

module mod_mul_serial #(
    parameter int Data_Width = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [Data_Width-1:0] i_a,
    input  logic [Data_Width-1:0] i_b,
    input  logic [Data_Width-1:0] i_p,
    output logic [Data_Width-1:0] o_R,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int CntW = (Data_Width > 1) ? $clog2(Data_Width) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [Data_Width-1:0] a_q, a_d;
    logic [Data_Width-1:0] b_q, b_d;
    logic [Data_Width-1:0] p_q, p_d;
    logic [Data_Width-1:0] acc_q, acc_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [Data_Width-1:0] r_d;
    logic                  busy_d;
    logic                  done_d;
    logic                  err_d;

    // Datapath intermediates. The extra top bit of each difference is the
    // borrow, which tells us whether the value was already below p.
    logic [Data_Width:0]   t1;
    logic [Data_Width+1:0] d1;
    logic [Data_Width:0]   t1_red;
    logic [Data_Width-1:0] a_sel;
    logic [Data_Width:0]   t2;
    logic [Data_Width+1:0] d2;
    logic [Data_Width:0]   t2_red;

    logic accept;
    logic range_bad;

`ifdef MOD_MUL_RANGE_CHECK_EN
    logic err_pend_q, err_pend_d;
    logic err_q;

    // A pending range error blocks new starts for the cycle it is being reported.
    assign accept    = i_start & ~err_pend_q;
    assign range_bad = (i_a >= i_p) | (i_b >= i_p) | (i_p < Data_Width'(2));
    assign o_err     = err_q;
`else
    assign accept    = i_start;
    assign range_bad = 1'b0;
    assign o_err     = 1'b0;
`endif

    // One interleaved step: R' = ((2R mod p) + b[i]*a) mod p.
    always_comb begin
        t1     = {acc_q, 1'b0};
        d1     = {1'b0, t1} - {2'b00, p_q};
        t1_red = d1[Data_Width+1] ? t1 : d1[Data_Width:0];
        a_sel  = b_q[cnt_q] ? a_q : '0;
        t2     = t1_red + {1'b0, a_sel};
        d2     = {1'b0, t2} - {2'b00, p_q};
        t2_red = d2[Data_Width+1] ? t2 : d2[Data_Width:0];
    end

    // Next-state and output logic for the IDLE/RUN controller.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned; an unassigned path would infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        r_d     = o_R;
        busy_d  = o_busy;
        done_d  = 1'b0;
`ifdef MOD_MUL_RANGE_CHECK_EN
        err_d      = err_q;
        err_pend_d = 1'b0;
`else
        err_d      = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef MOD_MUL_RANGE_CHECK_EN
                if (err_pend_q) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    r_d    = '0;
                    busy_d = 1'b0;
                end
`endif
                if (accept) begin
                    a_d    = i_a;
                    b_d    = i_b;
                    p_d    = i_p;
                    acc_d  = '0;
                    cnt_d  = CntW'(Data_Width - 1);
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    if (range_bad) begin
`ifdef MOD_MUL_RANGE_CHECK_EN
                        err_pend_d = 1'b1;
`endif
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                acc_d = t2_red[Data_Width-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    r_d     = t2_red[Data_Width-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers. Reset aborts any job in flight.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_R     <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
`ifdef MOD_MUL_RANGE_CHECK_EN
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, regardless of statement order.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            o_R     <= r_d;
            o_busy  <= busy_d;
            o_done  <= done_d;
`ifdef MOD_MUL_RANGE_CHECK_EN
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
`endif
        end
    end

`ifndef MOD_MUL_RANGE_CHECK_EN
    // Without range checking the error path does not exist.
    logic unused_err;
    assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_mod_mul_serial.sv
// Scoreboard testbench for mod_mul_serial.
// It instantiates one 8-bit DUT and one 256-bit DUT.
// The stimulus process pushes the expected result and completion cycle into a queue.
// A monitor process for each DUT pops the queue and compares on every o_done.
// The range-error vector follows MOD_MUL_RANGE_CHECK_EN when that macro is set.

module tb_mod_mul_serial;

    localparam int W8   = 8;
    localparam int W256 = 256;

    typedef struct {
        logic [255:0] r;
        logic         chk_r;
        logic         err;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            s8;
    logic [W8-1:0]   a8, b8, p8, r8;
    logic            busy8, done8, err8;
    logic            s256;
    logic [W256-1:0] a256, b256, p256, r256;
    logic            busy256, done256, err256;

    mod_mul_serial #(.Data_Width(W8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(s8),
        .i_a(a8), .i_b(b8), .i_p(p8),
        .o_R(r8), .o_busy(busy8), .o_done(done8), .o_err(err8)
    );

    mod_mul_serial #(.Data_Width(W256)) dut256 (
        .i_clk(clk), .i_rst(rst), .i_start(s256),
        .i_a(a256), .i_b(b256), .i_p(p256),
        .o_R(r256), .o_busy(busy256), .o_done(done256), .o_err(err256)
    );

    exp_t q8[$];
    exp_t q256[$];
    exp_t e8, e256;
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Called on a falling edge. The start is accepted on the next rising edge.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] p,
                          input logic [255:0] er, input logic chk, input logic ee, input int lat);
        a8 = a; b8 = b; p8 = p; s8 = 1'b1;
        q8.push_back('{r: er, chk_r: chk, err: ee, cyc: cyc + 1 + lat});
    endtask

    task automatic wait_empty8(input int budget);
        for (int i = 0; i < budget && q8.size() != 0; i++) @(negedge clk);
        check("q8_drained", 256'(q8.size()), 256'(0));
        q8.delete();
    endtask

    task automatic wait_empty256(input int budget);
        for (int i = 0; i < budget && q256.size() != 0; i++) @(negedge clk);
        check("q256_drained", 256'(q256.size()), 256'(0));
        q256.delete();
    endtask

    // Monitor for the 8-bit DUT.
    always @(negedge clk) begin
        if (rst === 1'b0 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("unexpected_done8", 256'(1), 256'(0));
            end else begin
                e8 = q8.pop_front();
                if (e8.chk_r) check("r8", 256'(r8), e8.r);
                check("err8", 256'(err8), 256'(e8.err));
                check("lat8", 256'(cyc), 256'(e8.cyc));
            end
        end
    end

    // Monitor for the 256-bit DUT.
    always @(negedge clk) begin
        if (rst === 1'b0 && done256 === 1'b1) begin
            if (q256.size() == 0) begin
                check("unexpected_done256", 256'(1), 256'(0));
            end else begin
                e256 = q256.pop_front();
                if (e256.chk_r) check("r256", r256, e256.r);
                check("err256", 256'(err256), 256'(e256.err));
                check("lat256", 256'(cyc), 256'(e256.cyc));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        s8 = 1'b0; a8 = '0; b8 = '0; p8 = '0;
        s256 = 1'b0; a256 = '0; b256 = '0; p256 = '0;
        repeat (2) @(negedge clk);
        check("rst_r8", 256'(r8), 256'(0));
        check("rst_busy8", 256'(busy8), 256'(0));
        check("rst_done8", 256'(done8), 256'(0));
        check("rst_err8", 256'(err8), 256'(0));
        check("rst_busy256", 256'(busy256), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        // 3 * 84 mod 251 = 1, because 84 is the inverse of 3.
        issue8(8'd3, 8'd84, 8'd251, 256'd1, 1'b1, 1'b0, W8);
        @(negedge clk);
        s8 = 1'b0;
        check("busy8_running", 256'(busy8), 256'(1));
        wait_empty8(40);

        // Back-to-back jobs with start held high, one every 9 cycles.
        issue8(8'd250, 8'd250, 8'd251, 256'd1, 1'b1, 1'b0, W8);
        repeat (W8 + 1) @(negedge clk);
        issue8(8'd17, 8'd0, 8'd251, 256'd0, 1'b1, 1'b0, W8);
        repeat (W8 + 1) @(negedge clk);
        issue8(8'd200, 8'd1, 8'd251, 256'd200, 1'b1, 1'b0, W8);
        @(negedge clk);
        s8 = 1'b0;
        wait_empty8(40);

        // Boundary and extra vectors.
        // 100*100 = 10000 = 39*251 + 211.
        issue8(8'd100, 8'd100, 8'd251, 256'd211, 1'b1, 1'b0, W8);
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);
        // Smallest legal modulus.
        issue8(8'd1, 8'd1, 8'd2, 256'd1, 1'b1, 1'b0, W8);
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);
        // (-1)*(-1) mod 255 = 1.
        issue8(8'd254, 8'd254, 8'd255, 256'd1, 1'b1, 1'b0, W8);
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);
        // a = 0 gives 0.
        issue8(8'd0, 8'd77, 8'd251, 256'd0, 1'b1, 1'b0, W8);
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);

        // 2^254 * 4 mod (2^255 - 19) = 2*19 = 38.
        a256 = 256'd1 << 254;
        b256 = 256'd4;
        p256 = (256'd1 << 255) - 256'd19;
        s256 = 1'b1;
        q256.push_back('{r: 256'd38, chk_r: 1'b1, err: 1'b0, cyc: cyc + 1 + W256});
        @(negedge clk);
        s256 = 1'b0;
        wait_empty256(400);

        // Reset in the middle of a job aborts it without an o_done.
        a8 = 8'd3; b8 = 8'd5; p8 = 8'd7; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy8", 256'(busy8), 256'(0));
        check("abort_done8", 256'(done8), 256'(0));
        check("abort_r8", 256'(r8), 256'(0));
        check("abort_r256", r256, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        // 3 * 5 = 15 and 15 mod 7 = 1.
        issue8(8'd3, 8'd5, 8'd7, 256'd1, 1'b1, 1'b0, W8);
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);

        // A start pulse during a run is ignored. 66 mod 13 = 1.
        issue8(8'd6, 8'd11, 8'd13, 256'd1, 1'b1, 1'b0, W8);
        @(negedge clk); s8 = 1'b0;
        repeat (3) @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; p8 = 8'd13; s8 = 1'b1;
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);
        repeat (14) @(negedge clk);

        // Operands out of range.
`ifdef MOD_MUL_RANGE_CHECK_EN
        issue8(8'd9, 8'd2, 8'd7, 256'd0, 1'b1, 1'b1, 1);
`else
        issue8(8'd9, 8'd2, 8'd7, 256'd0, 1'b0, 1'b0, W8);
`endif
        @(negedge clk); s8 = 1'b0;
        wait_empty8(40);
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
